// File: rtl/noisy_signal_gen.sv
// Tone-plus-noise sample generator: phase accumulator driving a quarter-wave sine LUT,
// summed with an attenuated 16-bit LFSR noise term through a 3-stage valid pipeline.
module noisy_signal_gen #(
    parameter int unsigned PHASE_W   = 24,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                Enable,
    input  logic [PHASE_W-1:0]  Tone_Step,
    input  logic                Noise_En,
    input  logic [2:0]          Noise_Shift,
    output logic signed [15:0]  Signal_Noise,
    output logic                Sample_Valid
);

    // First quadrant, sampled at odd multiples of pi/256 so the fold is symmetric.
    localparam logic [15:0] SineLut [64] = '{
        16'h0065, 16'h012E, 16'h01F6, 16'h02BF, 16'h0387, 16'h044E, 16'h0515, 16'h05DB,
        16'h06A1, 16'h0765, 16'h0828, 16'h08EA, 16'h09AA, 16'h0A69, 16'h0B26, 16'h0BE2,
        16'h0C9C, 16'h0D53, 16'h0E09, 16'h0EBD, 16'h0F6E, 16'h101D, 16'h10C9, 16'h1173,
        16'h121A, 16'h12BF, 16'h1360, 16'h13FF, 16'h149A, 16'h1533, 16'h15C7, 16'h1659,
        16'h16E7, 16'h1772, 16'h17F9, 16'h187C, 16'h18FC, 16'h1977, 16'h19EF, 16'h1A63,
        16'h1AD3, 16'h1B3E, 16'h1BA6, 16'h1C09, 16'h1C68, 16'h1CC2, 16'h1D18, 16'h1D69,
        16'h1DB6, 16'h1DFF, 16'h1E42, 16'h1E81, 16'h1EBC, 16'h1EF1, 16'h1F22, 16'h1F4E,
        16'h1F76, 16'h1F98, 16'h1FB5, 16'h1FCE, 16'h1FE2, 16'h1FF1, 16'h1FFA, 16'h1FFF
    };

    logic [PHASE_W-1:0] phase_q, phase_d;
    logic [15:0]        lfsr_q, lfsr_d;
    logic               lfsr_fb;

    logic [7:0]         p1_q, p1_d;
    logic signed [15:0] n1_q, n1_d;
    logic               v1_q;

    logic signed [15:0] s2_q, s2_d;
    logic signed [15:0] n2_q;
    logic               v2_q;

    logic signed [15:0] out_q, out_d;
    logic               valid_q;

    logic [3:0]         noise_sh;
    logic signed [15:0] noise_raw;
    logic signed [15:0] noise_term;

    logic [1:0]         quad;
    logic [5:0]         lut_idx;
    logic [15:0]        lut_val;

    // Fibonacci taps 16,14,13,11 map to bits 15,13,12,10.
    assign lfsr_fb    = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
    assign noise_sh   = {1'b0, Noise_Shift} + 4'd2;
    assign noise_raw  = $signed(lfsr_q) >>> noise_sh;
    assign noise_term = Noise_En ? noise_raw : 16'sd0;

    always_comb begin
        phase_d = phase_q;
        lfsr_d  = lfsr_q;
        p1_d    = p1_q;
        n1_d    = n1_q;
        if (Enable) begin
            phase_d = phase_q + Tone_Step;
            lfsr_d  = {lfsr_q[14:0], lfsr_fb};
            p1_d    = phase_q[PHASE_W-1 -: 8];
            n1_d    = noise_term;
        end
    end

    // Odd quadrants read the table backwards (63 - i == ~i), lower half-wave negates.
    always_comb begin
        quad    = p1_q[7:6];
        lut_idx = quad[0] ? ~p1_q[5:0] : p1_q[5:0];
        lut_val = SineLut[lut_idx];
        s2_d    = quad[1] ? -$signed(lut_val) : $signed(lut_val);
    end

    assign out_d = s2_q + n2_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            phase_q <= '0;
            lfsr_q  <= LFSR_SEED;
            p1_q    <= '0;
            n1_q    <= '0;
            v1_q    <= 1'b0;
            s2_q    <= '0;
            n2_q    <= '0;
            v2_q    <= 1'b0;
            out_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            phase_q <= phase_d;
            lfsr_q  <= lfsr_d;
            p1_q    <= p1_d;
            n1_q    <= n1_d;
            v1_q    <= Enable;
            v2_q    <= v1_q;
            valid_q <= v2_q;
            if (v1_q) begin
                s2_q <= s2_d;
                n2_q <= n1_q;
            end
            if (v2_q) begin
                out_q <= out_d;
            end
        end
    end

    assign Signal_Noise = out_q;
    assign Sample_Valid = valid_q;

endmodule
